// File: rtl/mux2_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_sel_arbiter
//
// Arbitrates two requesters that share a 2:1 mux. When a winner is picked the
// mux select is moved first. If the select actually changed, the block waits
// SETTLE_CYC cycles so the mux output can settle. It then grants the winner for
// up to HOLD_CYC cycles. A grant ends early as soon as the winner drops its
// request. Ties (req=11) go to the channel that was not served last. Every
// output is taken straight from a flop, so nothing in req can reach an output
// combinationally.
//
// Parameters
//   HOLD_CYC    cycles a grant is held (1..255)
//   SETTLE_CYC  settle cycles after a select change (0..15); 0 skips SETTLE
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   req[1:0]   in   request per mux input (bit0 -> D0, bit1 -> D1)
//   sel        out  mux select (registered)
//   gnt[1:0]   out  one-hot grant to the served requester (registered)
//   out_valid  out  mux output settled and owned by the grantee (registered)
//   busy       out  state is not IDLE (registered)
// -----------------------------------------------------------------------------
module mux2_sel_arbiter #(
  parameter int unsigned HOLD_CYC   = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic       sel,
  output logic [1:0] gnt,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYC);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);
  localparam bit         USE_SETTLE  = (SETTLE_CYC > 0);

  // Channel index to one-hot grant. gnt=11 can never be produced.
  function automatic logic [1:0] onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

  // Current state
  state_t     state;
  logic       lp;          // last-served channel; the other channel wins a tie
  logic [7:0] hold_cnt;
  logic [3:0] settle_cnt;

  // Next state
  state_t     state_n;
  logic       sel_n;
  logic [1:0] gnt_n;
  logic       out_valid_n;
  logic       busy_n;
  logic       lp_n;
  logic [7:0] hold_cnt_n;
  logic [3:0] settle_cnt_n;
  logic       win;

  // During SETTLE and HOLD the winner is always the channel that sel points
  // at. sel was loaded with the winner at the selection edge and is frozen
  // until the block is back in IDLE, so it doubles as the winner register.
  logic winner_req;
  assign winner_req = req[sel];

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_n      = state;
    sel_n        = sel;
    gnt_n        = gnt;
    out_valid_n  = out_valid;
    lp_n         = lp;
    hold_cnt_n   = hold_cnt;
    settle_cnt_n = settle_cnt;
    win          = sel;

    unique case (state)
      IDLE: begin
        gnt_n       = 2'b00;
        out_valid_n = 1'b0;
        if (req != 2'b00) begin
          // A lone request wins outright. On a tie the channel that was not
          // served last wins.
          win   = (req == 2'b11) ? ~lp : req[1];
          sel_n = win;
          if (USE_SETTLE && (win != sel)) begin
            state_n      = SETTLE;
            settle_cnt_n = SETTLE_LOAD;
          end else begin
            state_n     = HOLD;
            hold_cnt_n  = HOLD_LOAD;
            gnt_n       = onehot(win);
            out_valid_n = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (!winner_req) begin
          // Early release before the grant was ever issued.
          state_n      = IDLE;
          lp_n         = sel;
          settle_cnt_n = 4'd0;
        end else if (settle_cnt <= 4'd1) begin
          state_n      = HOLD;
          settle_cnt_n = 4'd0;
          hold_cnt_n   = HOLD_LOAD;
          gnt_n        = onehot(sel);
          out_valid_n  = 1'b1;
        end else begin
          settle_cnt_n = settle_cnt - 4'd1;
        end
      end

      HOLD: begin
        // The grant ends when the winner drops its request or the hold
        // count runs out. Either way the winner becomes the last-served
        // channel.
        if (!winner_req || (hold_cnt <= 8'd1)) begin
          state_n     = IDLE;
          lp_n        = sel;
          hold_cnt_n  = 8'd0;
          gnt_n       = 2'b00;
          out_valid_n = 1'b0;
        end else begin
          hold_cnt_n = hold_cnt - 8'd1;
        end
      end

      default: begin
        state_n     = IDLE;
        gnt_n       = 2'b00;
        out_valid_n = 1'b0;
      end
    endcase

    // busy is registered from the next state, so it tracks the state
    // register exactly and still has no combinational path from req.
    busy_n = (state_n != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge. With blocking assignments the
    // result would depend on statement order.
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      gnt        <= 2'b00;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      lp         <= 1'b1;
      hold_cnt   <= 8'd0;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      gnt        <= gnt_n;
      out_valid  <= out_valid_n;
      busy       <= busy_n;
      lp         <= lp_n;
      hold_cnt   <= hold_cnt_n;
      settle_cnt <= settle_cnt_n;
    end
  end

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_sel_arbiter
//
// Self-checking bench for mux2_sel_arbiter.
//
// dut uses HOLD_CYC=4 and SETTLE_CYC=1. dut_ns uses HOLD_CYC=4 and
// SETTLE_CYC=0.
//
// Each scenario is a table of rows {rst, req, sel, gnt, out_valid, busy}. The
// inputs of a row are driven on the falling edge and the expected outputs are
// pushed to a scoreboard queue at the same time. One time unit after the next
// rising edge, the expected value is popped and compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mux2_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic       sel;
  logic [1:0] gnt;
  logic       out_valid;
  logic       busy;

  logic       rst_ns;
  logic [1:0] req_ns;
  logic       sel_ns;
  logic [1:0] gnt_ns;
  logic       out_valid_ns;
  logic       busy_ns;

  int checks = 0;
  int errors = 0;

  logic [4:0] sb [$];

  mux2_sel_arbiter #(.HOLD_CYC(4), .SETTLE_CYC(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .busy      (busy)
  );

  mux2_sel_arbiter #(.HOLD_CYC(4), .SETTLE_CYC(0)) dut_ns (
    .clk       (clk),
    .rst       (rst_ns),
    .req       (req_ns),
    .sel       (sel_ns),
    .gnt       (gnt_ns),
    .out_valid (out_valid_ns),
    .busy      (busy_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one row's inputs on the falling edge and queues its expected
  // outputs.
  task automatic drive_row(input logic [7:0] r, input bit to_ns);
    @(negedge clk);
    if (to_ns) begin
      rst_ns = r[7];
      req_ns = r[6:5];
    end else begin
      rst = r[7];
      req = r[6:5];
    end
    sb.push_back(r[4:0]);
  endtask

  // Row format: rst | req[1:0] | sel | gnt[1:0] | out_valid | busy

  task automatic test_reset();
    logic [7:0] rows [$] = '{
      8'b1_11_0_00_0_0,
      8'b1_10_0_00_0_0,
      8'b1_01_0_00_0_0
    };
    logic [4:0] e, obs;
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i], 1'b0);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {sel, gnt, out_valid, busy};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset[%0d]: sel/gnt/ov/busy got %b want %b", i, obs, e);
      end
    end
  endtask

  // Single request on channel 0. sel stays 0, so there is no SETTLE. A rise
  // of req[1] during HOLD is ignored. The grant ends after 4 cycles, and one
  // IDLE cycle separates it from the re-grant.
  task automatic test_single_ch0();
    logic [7:0] rows [$] = '{
      8'b1_00_0_00_0_0,
      8'b0_01_0_01_1_1,
      8'b0_11_0_01_1_1,
      8'b0_01_0_01_1_1,
      8'b0_01_0_01_1_1,
      8'b0_01_0_00_0_0,
      8'b0_01_0_01_1_1,
      8'b0_00_0_00_0_0
    };
    logic [4:0] e, obs;
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i], 1'b0);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {sel, gnt, out_valid, busy};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_ch0[%0d]: sel/gnt/ov/busy got %b want %b", i, obs, e);
      end
    end
  endtask

  // Single request on channel 1: sel moves, one SETTLE cycle, then four HOLD
  // cycles. After that sel holds its value while the block is in IDLE.
  task automatic test_single_ch1();
    logic [7:0] rows [$] = '{
      8'b1_00_0_00_0_0,
      8'b0_10_1_00_0_1,
      8'b0_10_1_10_1_1,
      8'b0_10_1_10_1_1,
      8'b0_10_1_10_1_1,
      8'b0_10_1_10_1_1,
      8'b0_10_1_00_0_0,
      8'b0_00_1_00_0_0,
      8'b0_00_1_00_0_0
    };
    logic [4:0] e, obs;
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i], 1'b0);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {sel, gnt, out_valid, busy};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_ch1[%0d]: sel/gnt/ov/busy got %b want %b", i, obs, e);
      end
    end
  endtask

  // req=11 held: grants alternate 01, 10, 01. Each gap between grants is one
  // IDLE cycle followed by one SETTLE cycle.
  task automatic test_back_to_back();
    logic [7:0] rows [$] = '{
      8'b1_11_0_00_0_0,
      8'b0_11_0_01_1_1, 8'b0_11_0_01_1_1, 8'b0_11_0_01_1_1, 8'b0_11_0_01_1_1,
      8'b0_11_0_00_0_0,
      8'b0_11_1_00_0_1,
      8'b0_11_1_10_1_1, 8'b0_11_1_10_1_1, 8'b0_11_1_10_1_1, 8'b0_11_1_10_1_1,
      8'b0_11_1_00_0_0,
      8'b0_11_0_00_0_1,
      8'b0_11_0_01_1_1, 8'b0_11_0_01_1_1, 8'b0_11_0_01_1_1, 8'b0_11_0_01_1_1,
      8'b0_11_0_00_0_0
    };
    logic [4:0] e, obs;
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i], 1'b0);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {sel, gnt, out_valid, busy};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: sel/gnt/ov/busy got %b want %b", i, obs, e);
      end
    end
  endtask

  // Early release from HOLD and from SETTLE. The last-served pointer is
  // observed through the winner of the next req=11 tie.
  task automatic test_early_release();
    logic [7:0] rows [$] = '{
      8'b1_00_0_00_0_0,
      8'b0_01_0_01_1_1,
      8'b0_01_0_01_1_1,
      8'b0_00_0_00_0_0,  // req[0] drops in the 2nd HOLD cycle; lp becomes 0
      8'b0_11_1_00_0_1,  // tie goes to channel 1
      8'b0_11_1_10_1_1,
      8'b0_01_1_00_0_0,  // req[1] drops; lp becomes 1
      8'b0_01_0_00_0_1,  // channel 0 wins; sel moves, SETTLE
      8'b0_10_0_00_0_0,  // req[0] drops in SETTLE; req[1] rising is ignored; lp becomes 0
      8'b0_11_1_00_0_1,  // tie goes to channel 1
      8'b0_11_1_10_1_1
    };
    logic [4:0] e, obs;
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i], 1'b0);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {sel, gnt, out_valid, busy};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL early_release[%0d]: sel/gnt/ov/busy got %b want %b", i, obs, e);
      end
    end
  endtask

  // Reset in the 3rd HOLD cycle of a channel-1 grant, then reset in SETTLE.
  // After each reset the tie pointer is back to 1.
  task automatic test_reset_mid_grant();
    logic [7:0] rows [$] = '{
      8'b1_00_0_00_0_0,
      8'b0_10_1_00_0_1,
      8'b0_10_1_10_1_1,
      8'b0_10_1_10_1_1,
      8'b0_10_1_10_1_1,
      8'b1_10_0_00_0_0,  // reset in the 3rd HOLD cycle
      8'b0_11_0_01_1_1,  // lp=1, so channel 0 wins; sel=0, no SETTLE
      8'b1_11_0_00_0_0,
      8'b0_10_1_00_0_1,  // SETTLE
      8'b1_10_0_00_0_0,  // reset in SETTLE
      8'b0_00_0_00_0_0
    };
    logic [4:0] e, obs;
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i], 1'b0);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {sel, gnt, out_valid, busy};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_grant[%0d]: sel/gnt/ov/busy got %b want %b", i, obs, e);
      end
    end
  endtask

  // SETTLE_CYC=0: a select change goes straight to HOLD at the selection
  // edge.
  task automatic test_no_settle();
    logic [7:0] rows [$] = '{
      8'b1_00_0_00_0_0,
      8'b0_10_1_10_1_1,
      8'b0_10_1_10_1_1,
      8'b0_10_1_10_1_1,
      8'b0_10_1_10_1_1,
      8'b0_10_1_00_0_0,
      8'b0_01_0_01_1_1,
      8'b0_01_0_01_1_1
    };
    logic [4:0] e, obs;
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i], 1'b1);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {sel_ns, gnt_ns, out_valid_ns, busy_ns};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL no_settle[%0d]: sel/gnt/ov/busy got %b want %b", i, obs, e);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    req    = 2'b00;
    rst_ns = 1'b1;
    req_ns = 2'b00;
    repeat (2) @(posedge clk);

    test_reset();
    test_single_ch0();
    test_single_ch1();
    test_back_to_back();
    test_early_release();
    test_reset_mid_grant();
    test_no_settle();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
